// File: rtl/dvp_capture_ctrl.sv
// DVP frame-capture controller: arms on command, aligns to VSYNC and
// gates the receiver byte stream onto AXI-Stream with per-frame stats.
module dvp_capture_ctrl #(
   parameter int BYTE_CNT_W  = 24,
   parameter int LINE_CNT_W  = 12,
   parameter int FRAME_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   href,
   input  logic                   vsync,
   input  logic [7:0]             s_tdata,
   input  logic                   s_tvalid,
   input  logic                   s_tlast,
   output logic [7:0]             m_tdata,
   output logic                   m_tvalid,
   output logic                   m_tlast,
   input  logic                   m_tready,
   input  logic                   start,
   input  logic                   cont,
   input  logic                   stop,
   output logic                   busy,
   output logic                   frame_done,
   output logic [BYTE_CNT_W-1:0]  frame_bytes,
   output logic [LINE_CNT_W-1:0]  frame_lines,
   output logic [FRAME_CNT_W-1:0] frame_cnt,
   output logic                   overflow
);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_VS,
      WAIT_FRAME,
      CAPTURE,
      DONE
   } state_t;

   state_t state, state_nxt;

   logic vsync_d, href_d;
   logic cont_r, stop_pend;
   logic vs_rise, vs_fall, href_fall;
   logic arm, stop_req, cap, beat, cap_end;

   logic [BYTE_CNT_W-1:0] byte_cnt, byte_nxt;
   logic [LINE_CNT_W-1:0] line_cnt, line_nxt;

   assign vs_rise   = vsync & ~vsync_d;
   assign vs_fall   = ~vsync & vsync_d;
   assign href_fall = ~href & href_d;

   assign arm      = (state == IDLE) & start;
   assign stop_req = stop | stop_pend;
   assign cap      = (state == CAPTURE);
   assign beat     = cap & s_tvalid;
   assign cap_end  = cap & vs_rise;

   assign m_tdata = s_tdata;

   // next counts include the current cycle so the final beat lands in stats
   always_comb begin
      byte_nxt = byte_cnt;
      line_nxt = line_cnt;
      if (beat && byte_cnt != '1)
         byte_nxt = byte_cnt + BYTE_CNT_W'(1);
      if (cap && href_fall && line_cnt != '1)
         line_nxt = line_cnt + LINE_CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:
            if (start)
               state_nxt = WAIT_VS;
         WAIT_VS:
            if (stop_req)
               state_nxt = IDLE;
            else if (vs_rise)
               state_nxt = WAIT_FRAME;
         WAIT_FRAME:
            if (stop_req)
               state_nxt = IDLE;
            else if (vs_fall)
               state_nxt = CAPTURE;
         CAPTURE:
            if (vs_rise)
               state_nxt = DONE;
         DONE:
            state_nxt = (stop_req || !cont_r) ? IDLE : WAIT_FRAME;
         default:
            state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy       = (state != IDLE);
      frame_done = (state == DONE);
      m_tvalid   = 1'b0;
      m_tlast    = 1'b0;
      if (cap) begin
         m_tvalid = s_tvalid;
         m_tlast  = s_tlast;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vsync_d     <= 1'b0;
         href_d      <= 1'b0;
         cont_r      <= 1'b0;
         stop_pend   <= 1'b0;
         byte_cnt    <= '0;
         line_cnt    <= '0;
         frame_bytes <= '0;
         frame_lines <= '0;
         frame_cnt   <= '0;
         overflow    <= 1'b0;
      end else begin
         vsync_d <= vsync;
         href_d  <= href;

         if (arm)
            cont_r <= cont;

         if (state_nxt == IDLE)
            stop_pend <= 1'b0;
         else if (stop && state != IDLE)
            stop_pend <= 1'b1;

         if (arm || state == DONE) begin
            byte_cnt <= '0;
            line_cnt <= '0;
         end else if (cap) begin
            byte_cnt <= byte_nxt;
            line_cnt <= line_nxt;
         end

         if (cap_end) begin
            frame_bytes <= byte_nxt;
            frame_lines <= line_nxt;
            frame_cnt   <= frame_cnt + FRAME_CNT_W'(1);
         end

         if (arm)
            overflow <= 1'b0;
         else if (m_tvalid && !m_tready)
            overflow <= 1'b1;
      end
   end

endmodule
